// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational IF lookup, EX-stage training, and branch/mispredict perf counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_uncond,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        clr,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_taken;
  logic [CTR_W-1:0] up_ctr;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads the registered array only, so a same-cycle update is not seen.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
  end

  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_taken = upd_uncond || upd_taken;
    up_ctr   = ctr_q[up_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[IDX_W'(i)]  <= 1'b0;
        tag_q[IDX_W'(i)]    <= '0;
        target_q[IDX_W'(i)] <= '0;
        ctr_q[IDX_W'(i)]    <= '0;
      end
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd_valid) begin
        branch_count     <= branch_count + 32'd1;
        mispredict_count <= mispredict_count + {31'd0, upd_mispredict};
      end
      // clr takes priority over any allocation or training in the same cycle.
      if (clr) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          valid_q[IDX_W'(i)] <= 1'b0;
        end
      end else if (upd_valid) begin
        if (up_hit) begin
          if (up_taken) begin
            target_q[up_idx] <= upd_target;
            if (upd_uncond || up_ctr == CTR_MAX) ctr_q[up_idx] <= CTR_MAX;
            else                                 ctr_q[up_idx] <= up_ctr + CTR_W'(1);
          end else if (up_ctr != '0) begin
            ctr_q[up_idx] <= up_ctr - CTR_W'(1);
          end
        end else if (up_taken) begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= upd_target;
          ctr_q[up_idx]    <= upd_uncond ? CTR_MAX : CTR_WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, counter wrap, async reset,
// then randomized traffic checked against an arithmetic BTB model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int TAG_W   = 8;
  localparam int CMAX    = (1 << CTR_W) - 1;
  localparam int CWT     = 1 << (CTR_W - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_uncond = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] branch_count, mispredict_count;

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .clr(clr),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the BTB.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_bc, m_mc;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_bc = '0; m_mc = '0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic h, output logic t,
                               output logic [31:0] tg);
    int unsigned i;
    i  = idx_of(pc);
    h  = m_valid[i] && (m_tag[i] == tag_of(pc));
    t  = h && (m_ctr[i] >= CWT);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_update();
    int unsigned i;
    bit hit, tk;
    if (upd_valid) begin
      m_bc = m_bc + 1;
      if (upd_mispredict) m_mc = m_mc + 1;
    end
    if (clr) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (upd_valid) begin
      i   = idx_of(upd_pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
      tk  = upd_uncond || upd_taken;
      if (hit) begin
        if (upd_uncond)  begin m_ctr[i] = CMAX; m_tgt[i] = upd_target; end
        else if (tk)     begin m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1; m_tgt[i] = upd_target; end
        else             m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target;
        m_ctr[i]   = upd_uncond ? CMAX : CWT;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic unc, input logic tk, input logic [31:0] tgt,
                       input logic mp, input logic cl);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_uncond = unc;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mp; clr = cl;
    #1;
  endtask

  task automatic check_model();
    logic h, t;
    logic [31:0] tg;
    model_predict(lookup_pc, h, t, tg);
    chk("model_hit", {31'd0, pred_hit}, {31'd0, h});
    chk("model_taken", {31'd0, pred_taken}, {31'd0, t});
    chk("model_target", pred_target, tg);
    chk("model_branch_count", branch_count, m_bc);
    chk("model_mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        unc, tk;
    logic [31:0] tgt;
    logic        mp, cl;
    logic        eh, et;
    logic [31:0] etgt, ebc, emc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [31:0] lpc, logic uv, logic [31:0] upc, logic unc,
                              logic tk, logic [31:0] tgt, logic mp, logic cl,
                              logic eh, logic et, logic [31:0] etgt,
                              logic [31:0] ebc, logic [31:0] emc);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.unc = unc; v.tk = tk; v.tgt = tgt;
    v.mp = mp; v.cl = cl; v.eh = eh; v.et = et; v.etgt = etgt; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  initial begin
    // Expected outputs are the pre-update values seen while the row is driven.
    tbl.push_back(mk(32'h40, 1, 32'h40,  0, 1, 32'h80,  1, 0, 0, 0, 32'h44,  0, 0));
    tbl.push_back(mk(32'h40, 1, 32'h40,  0, 0, 32'h0,   0, 0, 1, 1, 32'h80,  1, 1));
    tbl.push_back(mk(32'h40, 1, 32'h40,  0, 0, 32'h0,   0, 0, 1, 0, 32'h44,  2, 1));
    tbl.push_back(mk(32'h40, 1, 32'h40,  0, 0, 32'h0,   0, 0, 1, 0, 32'h44,  3, 1));
    tbl.push_back(mk(32'h40, 1, 32'h40,  0, 1, 32'h80,  1, 0, 1, 0, 32'h44,  4, 1));
    tbl.push_back(mk(32'h40, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 0, 32'h44,  5, 2));
    tbl.push_back(mk(32'h40, 1, 32'h80,  0, 1, 32'h100, 0, 0, 1, 0, 32'h44,  5, 2));
    tbl.push_back(mk(32'h40, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h44,  6, 2));
    tbl.push_back(mk(32'h80, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 1, 32'h100, 6, 2));
    tbl.push_back(mk(32'h40, 1, 32'h40,  0, 1, 32'h80,  0, 0, 0, 0, 32'h44,  6, 2));
    tbl.push_back(mk(32'h40, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 1, 32'h80,  7, 2));
    tbl.push_back(mk(32'h200, 1, 32'h200, 1, 0, 32'h300, 0, 0, 0, 0, 32'h204, 7, 2));
    tbl.push_back(mk(32'h200, 1, 32'h200, 1, 1, 32'h340, 0, 0, 1, 1, 32'h300, 8, 2));
    tbl.push_back(mk(32'h200, 1, 32'h200, 0, 0, 32'h0,   0, 0, 1, 1, 32'h340, 9, 2));
    tbl.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 1, 32'h340, 10, 2));
    tbl.push_back(mk(32'h200, 1, 32'h240, 0, 1, 32'h400, 0, 1, 1, 1, 32'h340, 10, 2));
    tbl.push_back(mk(32'h240, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h244, 11, 2));
    tbl.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h204, 11, 2));
    tbl.push_back(mk(32'h40,  1, 32'h40,  0, 0, 32'h0,   0, 0, 0, 0, 32'h44,  11, 2));
    tbl.push_back(mk(32'h40,  0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h44,  12, 2));
    tbl.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 12, 2));

    // Asynchronous reset asserted between clock edges.
    lookup_pc = 32'h40;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("reset_hit", {31'd0, pred_hit}, 32'd0);
    chk("reset_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_target", pred_target, 32'h44);
    chk("reset_branch_count", branch_count, 32'd0);
    chk("reset_mispredict_count", mispredict_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[n]) begin
      drive(tbl[n].lpc, tbl[n].uv, tbl[n].upc, tbl[n].unc, tbl[n].tk, tbl[n].tgt,
            tbl[n].mp, tbl[n].cl);
      chk($sformatf("vec%0d_hit", n), {31'd0, pred_hit}, {31'd0, tbl[n].eh});
      chk($sformatf("vec%0d_taken", n), {31'd0, pred_taken}, {31'd0, tbl[n].et});
      chk($sformatf("vec%0d_target", n), pred_target, tbl[n].etgt);
      chk($sformatf("vec%0d_branch_count", n), branch_count, tbl[n].ebc);
      chk($sformatf("vec%0d_mispredict_count", n), mispredict_count, tbl[n].emc);
      commit();
    end

    // Counter wrap: preload all-ones, one more resolved branch wraps to zero.
    force dut.branch_count = 32'hFFFF_FFFF;
    #1 release dut.branch_count;
    m_bc = 32'hFFFF_FFFF;
    drive(32'h40, 1, 32'h40, 0, 0, 32'h0, 1, 0);
    chk("wrap_before", branch_count, 32'hFFFF_FFFF);
    commit();
    drive(32'h40, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    chk("wrap_after", branch_count, 32'd0);
    check_model();

    // Randomized traffic on a small pc set so entries alias and retrain.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc, upc;
      lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) lpc = $urandom;
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      drive(lpc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 4) == 0),
            1'($urandom), $urandom, 1'($urandom), 1'($urandom_range(0, 31) == 0));
      check_model();
      commit();
    end

    // Reset mid-operation: a pending update in that cycle is discarded.
    drive(32'h40, 1, 32'h40, 1, 1, 32'h500, 1, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_branch_count", branch_count, 32'd0);
    chk("midrst_mispredict_count", mispredict_count, 32'd0);
    chk("midrst_hit", {31'd0, pred_hit}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h40, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    chk("postrst_target", pred_target, 32'h44);
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised, direct-mapped branch target buffer with saturating-counter direction prediction for the 5-stage pipeline.
- Looked up combinationally in IF with the fetch PC; supplies predicted next PC.
- Trained by EX-stage branch/jump resolution.
- Keeps 32-bit branch and mispredict performance counters for the 7-seg/LED debug display.

Parameters:
- ENTRIES, 16: number of BTB entries; power of 2, >= 2. IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, >= 1.
- TAG_W, 8: tag width; IDX_W+TAG_W+2 <= 32.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- lookup_pc  in  32  IF fetch PC
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- upd_valid  in  1  EX resolves a branch/jump this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_uncond  in  1  1 = j/jal/jr, 0 = conditional branch
- upd_taken  in  1  actual direction (ignored when upd_uncond = 1, treated as taken)
- upd_target  in  32  actual taken target
- upd_mispredict  in  1  EX detected misprediction (qualified by upd_valid)
- clr  in  1  synchronous invalidate of all entries
- branch_count  out  32  resolved branch/jump count
- mispredict_count  out  32  mispredict count

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
- Entry contents: valid, tag, target[31:0], ctr[CTR_W-1:0].
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] & (tag[idx] == lookup tag).
  - pred_taken = pred_hit & ctr[idx][CTR_W-1].
  - pred_target = pred_taken ? target[idx] : lookup_pc + 4. The +4 wraps mod 2^32.
- Reset (async, active-high): all valid = 0, all ctr = 0, targets/tags = 0, both counts = 0.
  - Outputs after reset: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
- Update (rising clk, when upd_valid = 1 and rst = 0). Let WT = 2^(CTR_W-1) (weakly taken) and MAX = 2^CTR_W - 1.
  - Hit, unconditional: ctr <= MAX, target <= upd_target.
  - Hit, conditional, taken: ctr <= min(ctr+1, MAX), target <= upd_target.
  - Hit, conditional, not taken: ctr <= max(ctr-1, 0); target unchanged.
  - Miss, unconditional: allocate (overwrite): valid = 1, tag, target, ctr <= MAX.
  - Miss, conditional, taken: allocate with ctr <= WT.
  - Miss, conditional, not taken: no change.
  - branch_count += 1.
  - mispredict_count += upd_mispredict.
  - Both counters wrap 0xFFFFFFFF -> 0.
- Same-cycle lookup and update of the same idx: the lookup returns pre-update contents. The new contents are visible from the next cycle. There is no write-through.
- clr = 1 at clk: all valid <= 0. Counters, ctr and targets are untouched.
  - If clr and upd_valid coincide, clr wins for the entry array (no allocation). branch_count and mispredict_count still update.
- rst mid-operation: immediate clear regardless of clk. An update pending in the same cycle is lost.
- upd_valid = 0: no state change except via clr.
- Storage is flops (no RAM inference requirement). There are no X on outputs after reset.

Test Plan:
ENTRIES=16, CTR_W=2, TAG_W=8. 0x40 and 0x80 map to idx 0, tags 1/2.

1. Reset state: assert rst asynchronously between edges, then release; lookup_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044, branch_count=0, mispredict_count=0.
2. Allocate and train down:
   - upd cond taken, pc 0x40, target 0x80, mispredict=1 -> next cycle lookup 0x40: hit=1, taken=1 (ctr=2), target=0x80, branch_count=1, mispredict_count=1.
   - Two not-taken updates -> ctr 1 then 0, pred_taken=0, target 0x44.
   - Third not-taken -> ctr stays 0.
   - One taken -> ctr=1, still pred_taken=0.
3. Aliasing: with 0x40 allocated, upd cond taken pc 0x80 target 0x100 -> lookup 0x40 hit=0, target 0x44; lookup 0x80 hit=1, target 0x100.
4. Same-cycle read/update: lookup 0x40 (miss) while updating 0x40 taken target 0x80 -> that cycle pred_hit=0; next cycle pred_hit=1, target 0x80.
5. Unconditional and jr retarget:
   - upd_uncond pc 0x200 target 0x300 -> ctr=3, pred target 0x300.
   - Second update target 0x340 -> pred target 0x340.
   - One cond not-taken update at 0x200 -> ctr=2, still taken.
6. clr with simultaneous update: clr=1 together with upd_valid on pc 0x240 -> all lookups miss next cycle, branch_count incremented.
   - Preload branch_count=0xFFFFFFFF via 2^32-1 updates (or force) then one more update -> wraps to 0.
